text_blit_engine: RTL and testbench

TEXT_BLIT_ENGINE -- requirements
Module: text_blit_engine

---
 rtl/text_blit_engine.sv | 131 +++++++++++++
 tb/tb_text_blit_engine.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/text_blit_engine.sv
// rtl/text_blit_engine.sv - glyph-to-framebuffer blitter
// Copies one 8x16 glyph into a byte-per-8-pixel framebuffer cell, one pixel line per READ/WRITE pair.
module text_blit_engine #(
    parameter int unsigned COLS = 80,
    parameter int unsigned ROWS = 30
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_char,
    input  logic [6:0]  cmd_col,
    input  logic [4:0]  cmd_row,
    input  logic        cmd_inv,
    output logic [11:0] glyph_addr,
    input  logic [7:0]  glyph_data,
    output logic        fb_we,
    input  logic        fb_ready,
    output logic [15:0] fb_addr,
    output logic [7:0]  fb_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  line_q, line_d;
    logic [7:0]  char_q, char_d;
    logic [6:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic        inv_q, inv_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        accept;
    logic        in_range;
    logic [15:0] pix_line;

    assign accept   = cmd_valid && cmd_ready;
    assign in_range = (32'(cmd_col) < COLS) && (32'(cmd_row) < ROWS);

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        char_d  = char_q;
        col_d   = col_q;
        row_d   = row_q;
        inv_d   = inv_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    char_d = cmd_char;
                    col_d  = cmd_col;
                    row_d  = cmd_row;
                    inv_d  = cmd_inv;
                    line_d = 4'd0;
                    if (in_range) begin
                        state_d = S_READ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                // ROM row for the current line is captured here and held through any write stall
                data_d  = glyph_data;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (fb_ready) begin
                    if (line_q == 4'd15) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        line_d  = line_q + 4'd1;
                        state_d = S_READ;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            line_q  <= 4'd0;
            char_q  <= 8'd0;
            col_q   <= 7'd0;
            row_q   <= 5'd0;
            inv_q   <= 1'b0;
            data_q  <= 8'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            char_q  <= char_d;
            col_q   <= col_d;
            row_q   <= row_d;
            inv_q   <= inv_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Pixel line index is row*16 + line; the 16-bit product covers the full ROWS*16*COLS space
    assign pix_line   = {7'd0, row_q, line_q};
    assign fb_addr    = pix_line * 16'(COLS) + {9'd0, col_q};
    assign glyph_addr = {char_q, line_q};
    assign fb_wdata   = data_q ^ {8{inv_q}};
    assign fb_we      = (state_q == S_WRITE);
    assign busy       = (state_q != S_IDLE);
    assign cmd_ready  = (state_q == S_IDLE) && !Reset;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_text_blit_engine.sv
// tb/tb_text_blit_engine.sv - self-checking bench for text_blit_engine
// Reference: each command expands to 16 (addr, byte) writes from row/col/line arithmetic and a ROM array.
module tb_text_blit_engine;

    logic        Clk;
    logic        Reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_char;
    logic [6:0]  cmd_col;
    logic [4:0]  cmd_row;
    logic        cmd_inv;
    logic [11:0] glyph_addr;
    logic [7:0]  glyph_data;
    logic        fb_we;
    logic        fb_ready;
    logic [15:0] fb_addr;
    logic [7:0]  fb_wdata;
    logic        busy;
    logic        done;
    logic        err;

    logic [7:0]  rom [0:4095];
    int          total;
    int          bad;

    text_blit_engine #(.COLS(80), .ROWS(30)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_char   (cmd_char),
        .cmd_col    (cmd_col),
        .cmd_row    (cmd_row),
        .cmd_inv    (cmd_inv),
        .glyph_addr (glyph_addr),
        .glyph_data (glyph_data),
        .fb_we      (fb_we),
        .fb_ready   (fb_ready),
        .fb_addr    (fb_addr),
        .fb_wdata   (fb_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    assign glyph_data = rom[glyph_addr];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int exp_addr(input int row, input int col, input int line);
        return (row * 16 + line) * 80 + col;
    endfunction

    task automatic run_cmd(input int ch, input int col, input int row, input int inv,
                           input int stall_line, input int rand_stall, input int reset_line,
                           output int last_addr);
        int wr_n, first_we, done_k, stalls, held, errs, aborted, k;
        int ea, ed, we_after, done_after;
        @(negedge Clk);
        cmd_valid = 1'b1;
        cmd_char  = 8'(ch);
        cmd_col   = 7'(col);
        cmd_row   = 5'(row);
        cmd_inv   = 1'(inv);
        fb_ready  = 1'b1;
        chk("ready_at_cmd", 32'(cmd_ready), 1);
        wr_n = 0; first_we = -1; done_k = -1; stalls = 0; held = 0; errs = 0; aborted = 0;
        last_addr = -1;
        k = 0;
        while (k < 400 && done_k < 0 && aborted == 0) begin
            k++;
            @(negedge Clk);
            cmd_valid = 1'b0;
            if (err) errs++;
            if (done) begin
                done_k = k;
                chk("idle_busy_at_done", 32'(busy), 0);
                chk("ready_at_done", 32'(cmd_ready), 1);
            end else if (fb_we) begin
                if (first_we < 0) first_we = k;
                ea = exp_addr(row, col, wr_n);
                ed = int'(rom[(ch * 16 + wr_n) % 4096]) ^ (inv != 0 ? 255 : 0);
                chk("fb_addr", 32'(fb_addr), 32'(ea));
                chk("fb_wdata", 32'(fb_wdata), 32'(ed));
                last_addr = int'(fb_addr);
                if (wr_n == reset_line) begin
                    Reset = 1'b1;
                    aborted = 1;
                end else begin
                    if (wr_n == stall_line) held++;
                    if ((wr_n == stall_line && stalls < 5) ||
                        (rand_stall != 0 && $urandom_range(0, 3) == 0)) begin
                        fb_ready = 1'b0;
                        if (wr_n == stall_line) stalls++;
                    end else begin
                        fb_ready = 1'b1;
                        wr_n++;
                    end
                end
            end else if (busy) begin
                chk("glyph_addr", 32'(glyph_addr), 32'(ch * 16 + wr_n));
                fb_ready = 1'b1;
            end
        end
        fb_ready = 1'b1;
        if (aborted != 0) begin
            @(negedge Clk);
            chk("rst_fb_we", 32'(fb_we), 0);
            chk("rst_ready", 32'(cmd_ready), 0);
            chk("rst_busy", 32'(busy), 0);
            Reset = 1'b0;
            we_after = 0; done_after = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge Clk);
                if (fb_we) we_after++;
                if (done) done_after++;
            end
            chk("rst_no_we", 32'(we_after), 0);
            chk("rst_no_done", 32'(done_after), 0);
            chk("rst_ready_after", 32'(cmd_ready), 1);
        end else begin
            chk("writes", 32'(wr_n), 16);
            chk("done_seen", 32'(done_k > 0), 1);
            chk("no_err", 32'(errs), 0);
            if (rand_stall == 0 && stall_line < 0) begin
                chk("first_we_lat", 32'(first_we), 2);
                chk("done_lat", 32'(done_k), 33);
            end
            if (stall_line >= 0) begin
                chk("stall_held", 32'(held), 6);
                chk("stall_done_lat", 32'(done_k), 38);
            end
            @(negedge Clk);
            chk("done_one_cycle", 32'(done), 0);
        end
    endtask

    task automatic err_cmd(input int col, input int row);
        int errs, we_any, busy_any, nready, done_any;
        @(negedge Clk);
        cmd_valid = 1'b1;
        cmd_char  = 8'h55;
        cmd_col   = 7'(col);
        cmd_row   = 5'(row);
        cmd_inv   = 1'b0;
        errs = 0; we_any = 0; busy_any = 0; nready = 0; done_any = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge Clk);
            cmd_valid = 1'b0;
            if (i == 1) chk("err_pulse_k1", 32'(err), 1);
            if (err) errs++;
            if (fb_we) we_any++;
            if (busy) busy_any++;
            if (!cmd_ready) nready++;
            if (done) done_any++;
        end
        chk("err_count", 32'(errs), 1);
        chk("err_no_we", 32'(we_any), 0);
        chk("err_no_busy", 32'(busy_any), 0);
        chk("err_ready", 32'(nready), 0);
        chk("err_no_done", 32'(done_any), 0);
    endtask

    task automatic back_to_back();
        int d1, d2, first_busy, last_busy, idle_gap, writes;
        int busy_hist [0:119];
        @(negedge Clk);
        cmd_valid = 1'b1;
        cmd_char  = 8'h33;
        cmd_col   = 7'd10;
        cmd_row   = 5'd3;
        cmd_inv   = 1'b0;
        fb_ready  = 1'b1;
        d1 = -1; d2 = -1; first_busy = -1; last_busy = -1; writes = 0;
        for (int k = 1; k < 120; k++) begin
            @(negedge Clk);
            if (d1 >= 0 && k > d1) cmd_valid = 1'b0;
            busy_hist[k] = busy ? 1 : 0;
            if (busy) begin
                if (first_busy < 0) first_busy = k;
                last_busy = k;
            end
            if (fb_we && fb_ready) writes++;
            if (done) begin
                if (d1 < 0) d1 = k;
                else if (d2 < 0) d2 = k;
            end
        end
        cmd_valid = 1'b0;
        idle_gap = 0;
        for (int k = 1; k < 120; k++) begin
            if (first_busy > 0 && k > first_busy && k < last_busy && busy_hist[k] == 0) idle_gap++;
        end
        chk("b2b_d1", 32'(d1), 33);
        chk("b2b_spacing", 32'(d2 - d1), 33);
        chk("b2b_idle_gap", 32'(idle_gap), 1);
        chk("b2b_writes", 32'(writes), 32);
    endtask

    initial begin
        int la;
        total = 0;
        bad = 0;
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        rom[12'h410] = 8'h00;
        rom[12'h41F] = 8'hFF;
        Reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_char  = 8'h00;
        cmd_col   = 7'd0;
        cmd_row   = 5'd0;
        cmd_inv   = 1'b0;
        fb_ready  = 1'b1;
        repeat (3) @(negedge Clk);
        chk("ready_in_reset", 32'(cmd_ready), 0);
        Reset = 1'b0;
        @(negedge Clk);
        chk("rv_ready", 32'(cmd_ready), 1);
        chk("rv_busy", 32'(busy), 0);
        chk("rv_done", 32'(done), 0);
        chk("rv_err", 32'(err), 0);
        chk("rv_fb_we", 32'(fb_we), 0);
        chk("rv_fb_addr", 32'(fb_addr), 0);
        chk("rv_fb_wdata", 32'(fb_wdata), 0);
        chk("rv_glyph_addr", 32'(glyph_addr), 0);

        run_cmd(8'h41, 2, 1, 0, -1, 0, -1, la);
        chk("a_last_addr", 32'(la), 2482);
        run_cmd(8'h41, 2, 1, 1, -1, 0, -1, la);
        run_cmd(8'h41, 2, 1, 0, 7, 0, -1, la);
        run_cmd(8'h7E, 79, 29, 0, -1, 0, -1, la);
        chk("corner_last_addr", 32'(la), 38399);
        err_cmd(80, 0);
        err_cmd(0, 30);
        err_cmd(127, 31);
        run_cmd(8'h12, 5, 4, 0, -1, 0, 5, la);
        run_cmd(8'h41, 2, 1, 0, -1, 0, -1, la);
        back_to_back();
        for (int n = 0; n < 8; n++) begin
            run_cmd(int'($urandom_range(0, 255)), int'($urandom_range(0, 79)),
                    int'($urandom_range(0, 29)), int'($urandom_range(0, 1)),
                    -1, n % 2, -1, la);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
